// File: rtl/dsp_pipe_pkg.sv
// Shared constants and helpers for the DSP48A1 pipeline delay line.
// Feature macro used by the pipeline: DSP_PIPE_GATE_EN (data gating on invalid bubbles).
package dsp_pipe_pkg;

    localparam int DSP_WIDTH          = 48;
    localparam int DSP_PIPE_MAX_DEPTH = 8;

    // Width of the occupancy counter: enough to hold 0..depth, never narrower than one bit.
    function automatic int level_width(input int depth);
        int w;
        w = $clog2(depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dsp_pipe_delay_if.sv
// Data/handshake bundle between a pipeline delay stage and its neighbours.
// The master side drives samples and controls, the slave side (the delay line) returns them.
interface dsp_pipe_delay_if #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 1
);
    import dsp_pipe_pkg::*;

    localparam int LW = level_width(DEPTH);

    logic             clken;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] din;
    logic             out_valid;
    logic [WIDTH-1:0] dout;
    logic             busy;
    logic [LW-1:0]    level;

    modport master (
        output clken, flush, in_valid, din,
        input  out_valid, dout, busy, level
    );

    modport slave (
        input  clken, flush, in_valid, din,
        output out_valid, dout, busy, level
    );

endinterface

// File: rtl/dsp_pipe_cell.sv
// One register stage of the delay line: data plus valid bit.
// With DSP_PIPE_GATE_EN defined the data register only loads on a valid sample.
module dsp_pipe_cell
    import dsp_pipe_pkg::*;
#(
    parameter int WIDTH = DSP_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clken,
    input  logic             flush,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Stage register: reset clears everything, flush drops validity but keeps data, enable advances.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (clken) begin
            valid <= prev_valid;
`ifdef DSP_PIPE_GATE_EN
            if (prev_valid) begin
                data <= prev_data;
            end
`else
            data <= prev_data;
`endif
        end
    end

endmodule

// File: rtl/dsp_pipe_delay.sv
// Parametrised WIDTH x DEPTH pipeline delay line with shared enable, flush and occupancy count.
// DEPTH=0 is a combinational pass-through. Optional macro: DSP_PIPE_GATE_EN
// (bubbles do not toggle data registers and dout reads zero while out_valid is low).
module dsp_pipe_delay
    import dsp_pipe_pkg::*;
#(
    parameter int WIDTH = DSP_WIDTH,
    parameter int DEPTH = 1
) (
    input logic             clk,
    input logic             reset,
    dsp_pipe_delay_if.slave bus
);

    localparam int LW = level_width(DEPTH);

    if (DEPTH < 0 || DEPTH > DSP_PIPE_MAX_DEPTH || WIDTH < 1 || WIDTH > 64) begin : g_bad_param
        $error("dsp_pipe_delay: illegal parameters WIDTH=%0d DEPTH=%0d", WIDTH, DEPTH);
    end

    if (DEPTH == 0) begin : g_bypass

        // Clock and controls have no effect without registers; collected here so they read as intentionally unused.
        wire unused_ok = &{1'b0, clk, reset, bus.clken, bus.flush};

        assign bus.dout      = bus.din;
        assign bus.out_valid = bus.in_valid;
        assign bus.busy      = 1'b0;
        assign bus.level     = '0;

    end else begin : g_pipe

        localparam logic [LW-1:0] ONE = LW'(1);

        // Index 0 is the incoming sample, index i+1 is the output of stage i.
        logic [DEPTH:0][WIDTH-1:0] stage_data;
        logic [DEPTH:0]            stage_valid;
        logic [LW-1:0]             level_q;
        logic                      last_valid;

        assign stage_data[0]  = bus.din;
        assign stage_valid[0] = bus.in_valid;
        assign last_valid     = stage_valid[DEPTH];

        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            dsp_pipe_cell #(
                .WIDTH(WIDTH)
            ) u_cell (
                .clk        (clk),
                .reset      (reset),
                .clken      (bus.clken),
                .flush      (bus.flush),
                .prev_valid (stage_valid[i]),
                .prev_data  (stage_data[i]),
                .valid      (stage_valid[i+1]),
                .data       (stage_data[i+1])
            );
        end

        // Occupancy tracks entries minus exits on enabled edges; it mirrors the valid bits so it stays within 0..DEPTH.
        always_ff @(posedge clk) begin
            if (reset || bus.flush) begin
                level_q <= '0;
            end else if (bus.clken) begin
                case ({bus.in_valid, last_valid})
                    2'b10:   level_q <= level_q + ONE;
                    2'b01:   level_q <= level_q - ONE;
                    default: level_q <= level_q;
                endcase
            end
        end

        assign bus.out_valid = last_valid;
        assign bus.level     = level_q;
        assign bus.busy      = (level_q != '0);
`ifdef DSP_PIPE_GATE_EN
        assign bus.dout      = last_valid ? stage_data[DEPTH] : '0;
`else
        assign bus.dout      = stage_data[DEPTH];
`endif

    end

endmodule

// File: tb/tb_dsp_pipe_delay.sv
// Self-checking bench for dsp_pipe_delay at DEPTH 3, 4, 2 and 0 (WIDTH 48).
// Honors DSP_PIPE_GATE_EN for the expected dout of invalid cycles.
module tb_dsp_pipe_delay;

`ifdef DSP_PIPE_GATE_EN
    localparam bit GATED = 1'b1;
`else
    localparam bit GATED = 1'b0;
`endif

    logic clk;
    logic reset;

    int compared;
    int mismatched;

    dsp_pipe_delay_if #(.WIDTH(48), .DEPTH(3)) b3 ();
    dsp_pipe_delay_if #(.WIDTH(48), .DEPTH(4)) b4 ();
    dsp_pipe_delay_if #(.WIDTH(48), .DEPTH(2)) b2 ();
    dsp_pipe_delay_if #(.WIDTH(48), .DEPTH(0)) b0 ();

    dsp_pipe_delay #(.WIDTH(48), .DEPTH(3)) u_d3 (.clk(clk), .reset(reset), .bus(b3));
    dsp_pipe_delay #(.WIDTH(48), .DEPTH(4)) u_d4 (.clk(clk), .reset(reset), .bus(b4));
    dsp_pipe_delay #(.WIDTH(48), .DEPTH(2)) u_d2 (.clk(clk), .reset(reset), .bus(b2));
    dsp_pipe_delay #(.WIDTH(48), .DEPTH(0)) u_d0 (.clk(clk), .reset(reset), .bus(b0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        fl;
        logic        iv;
        logic [47:0] din;
        logic        ev;
        logic [47:0] edout;
        int          elvl;
    } vec_t;

    vec_t tbl [18];

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic rst, input logic en, input logic fl, input logic iv, input logic [47:0] d);
        reset       = rst;
        b3.clken    = en;
        b3.flush    = fl;
        b3.in_valid = iv;
        b3.din      = d;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        b3.clken = 1'b0; b3.flush = 1'b0; b3.in_valid = 1'b0; b3.din = '0;
        b4.clken = 1'b0; b4.flush = 1'b0; b4.in_valid = 1'b0; b4.din = '0;
        b2.clken = 1'b0; b2.flush = 1'b0; b2.in_valid = 1'b0; b2.din = '0;
        b0.clken = 1'b0; b0.flush = 1'b0; b0.in_valid = 1'b0; b0.din = '0;

        // DEPTH=3: streaming ramp, then a stall of four cycles with ignored input.
        //            rst   en    fl    iv    din       ev    edout     lvl
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 48'h0,    1'b0, 48'h0,    0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 48'h1,    1'b0, 48'h0,    1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 48'h2,    1'b0, 48'h0,    2};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 48'h3,    1'b1, 48'h1,    3};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 48'h4,    1'b1, 48'h2,    3};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 48'h0,    1'b1, 48'h3,    2};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 48'h0,    1'b1, 48'h4,    1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 48'h0,    1'b0, 48'h0,    0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 48'h0,    1'b0, 48'h0,    0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 48'hA,    1'b0, 48'h0,    1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 48'hB,    1'b0, 48'h0,    2};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 48'h77,   1'b0, 48'h0,    2};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 48'h77,   1'b0, 48'h0,    2};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 48'h77,   1'b0, 48'h0,    2};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 48'h77,   1'b0, 48'h0,    2};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 48'h0,    1'b1, 48'hA,    2};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 48'h0,    1'b1, 48'hB,    1};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 48'h0,    1'b0, 48'h0,    0};

        for (int i = 0; i < 18; i++) begin
            apply_stimulus(tbl[i].rst, tbl[i].en, tbl[i].fl, tbl[i].iv, tbl[i].din);
            tick();
            check_output($sformatf("d3_row%0d_out_valid", i), 64'(b3.out_valid), 64'(tbl[i].ev));
            check_output($sformatf("d3_row%0d_dout", i), 64'(b3.dout), 64'(tbl[i].edout));
            check_output($sformatf("d3_row%0d_level", i), 64'(b3.level), 64'(tbl[i].elvl));
            check_output($sformatf("d3_row%0d_busy", i), 64'(b3.busy), 64'(tbl[i].elvl != 0));
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 48'h0);

        // DEPTH=4: flush with enable and a valid incoming sample drops everything in flight.
        pulse_reset();
        b4.clken = 1'b1;
        b4.in_valid = 1'b1;
        b4.din = 48'h11; tick();
        b4.din = 48'h22; tick();
        b4.din = 48'h33; tick();
        check_output("d4_level_before_flush", 64'(b4.level), 64'd3);
        check_output("d4_busy_before_flush", 64'(b4.busy), 64'd1);
        b4.flush = 1'b1;
        b4.din = 48'hFF;
        tick();
        b4.flush = 1'b0;
        b4.in_valid = 1'b0;
        b4.din = 48'h0;
        check_output("d4_level_after_flush", 64'(b4.level), 64'd0);
        check_output("d4_busy_after_flush", 64'(b4.busy), 64'd0);
        check_output("d4_out_valid_after_flush", 64'(b4.out_valid), 64'd0);
        for (int k = 0; k < 4; k++) begin
            logic [47:0] raw;
            raw = (k == 0) ? 48'h11 : (k == 1) ? 48'h22 : (k == 2) ? 48'h33 : 48'h0;
            tick();
            check_output($sformatf("d4_drain%0d_out_valid", k), 64'(b4.out_valid), 64'd0);
            check_output($sformatf("d4_drain%0d_level", k), 64'(b4.level), 64'd0);
            check_output($sformatf("d4_drain%0d_dout", k), 64'(b4.dout), GATED ? 64'd0 : 64'(raw));
        end

        // DEPTH=4: flush while stalled still clears validity.
        b4.in_valid = 1'b1;
        b4.din = 48'h44;
        tick();
        check_output("d4_level_reload", 64'(b4.level), 64'd1);
        b4.in_valid = 1'b0;
        b4.clken = 1'b0;
        b4.flush = 1'b1;
        tick();
        b4.flush = 1'b0;
        check_output("d4_level_stall_flush", 64'(b4.level), 64'd0);
        check_output("d4_busy_stall_flush", 64'(b4.busy), 64'd0);
        b4.clken = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_output($sformatf("d4_post_stall%0d_out_valid", k), 64'(b4.out_valid), 64'd0);
        end
        b4.clken = 1'b0;

        // DEPTH=2: reset beats a simultaneous flush and valid sample.
        pulse_reset();
        b2.clken = 1'b1;
        b2.in_valid = 1'b1;
        b2.din = 48'h55; tick();
        b2.din = 48'h66; tick();
        check_output("d2_pre_reset_out_valid", 64'(b2.out_valid), 64'd1);
        check_output("d2_pre_reset_dout", 64'(b2.dout), 64'h55);
        check_output("d2_pre_reset_level", 64'(b2.level), 64'd2);
        reset = 1'b1;
        b2.flush = 1'b1;
        b2.din = 48'h999;
        tick();
        reset = 1'b0;
        b2.flush = 1'b0;
        check_output("d2_reset_dout", 64'(b2.dout), 64'd0);
        check_output("d2_reset_out_valid", 64'(b2.out_valid), 64'd0);
        check_output("d2_reset_level", 64'(b2.level), 64'd0);
        b2.din = 48'h123456789ABC;
        tick();
        check_output("d2_big_e1_out_valid", 64'(b2.out_valid), 64'd0);
        check_output("d2_big_e1_level", 64'(b2.level), 64'd1);
        b2.in_valid = 1'b0;
        b2.din = 48'h0;
        tick();
        check_output("d2_big_e2_out_valid", 64'(b2.out_valid), 64'd1);
        check_output("d2_big_e2_dout", 64'(b2.dout), 64'h123456789ABC);
        check_output("d2_big_e2_level", 64'(b2.level), 64'd1);
        tick();
        check_output("d2_big_e3_out_valid", 64'(b2.out_valid), 64'd0);
        check_output("d2_big_e3_level", 64'(b2.level), 64'd0);

        // DEPTH=2: alternating valid samples 5, bubble(6), 7.
        pulse_reset();
        b2.in_valid = 1'b1; b2.din = 48'h5; tick();
        check_output("d2_alt_e1_out_valid", 64'(b2.out_valid), 64'd0);
        check_output("d2_alt_e1_level", 64'(b2.level), 64'd1);
        b2.in_valid = 1'b0; b2.din = 48'h6; tick();
        check_output("d2_alt_e2_out_valid", 64'(b2.out_valid), 64'd1);
        check_output("d2_alt_e2_dout", 64'(b2.dout), 64'h5);
        b2.in_valid = 1'b1; b2.din = 48'h7; tick();
        check_output("d2_alt_e3_out_valid", 64'(b2.out_valid), 64'd0);
        check_output("d2_alt_e3_dout", 64'(b2.dout), GATED ? 64'd0 : 64'h6);
        check_output("d2_alt_e3_level", 64'(b2.level), 64'd1);
        b2.in_valid = 1'b0; b2.din = 48'h0; tick();
        check_output("d2_alt_e4_out_valid", 64'(b2.out_valid), 64'd1);
        check_output("d2_alt_e4_dout", 64'(b2.dout), 64'h7);
        tick();
        check_output("d2_alt_e5_out_valid", 64'(b2.out_valid), 64'd0);
        check_output("d2_alt_e5_dout", 64'(b2.dout), 64'd0);
        check_output("d2_alt_e5_level", 64'(b2.level), 64'd0);
        b2.clken = 1'b0;

        // DEPTH=0: combinational pass-through.
        b0.din = 48'hDEAD;
        b0.in_valid = 1'b1;
        #1;
        check_output("d0_dout", 64'(b0.dout), 64'hDEAD);
        check_output("d0_out_valid", 64'(b0.out_valid), 64'd1);
        check_output("d0_level", 64'(b0.level), 64'd0);
        check_output("d0_busy", 64'(b0.busy), 64'd0);
        b0.in_valid = 1'b0;
        b0.din = 48'hBEEF;
        #1;
        check_output("d0_invalid_out_valid", 64'(b0.out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dsp_pipe_delay.md
# dsp_pipe_delay

Parametrised pipeline register stage for the DSP48A1 datapath: a WIDTH-bit, DEPTH-deep delay line with a shared clock enable, per-stage valid tracking, a flush control and an occupancy count. It replaces the single-register bypassable stage at any operand or result point (A, B, C, D, M, P) where a pipeline depth other than one, or knowledge of in-flight data, is required. DEPTH=0 yields a pure combinational pass-through.

## Interface
- WIDTH, 48, data width in bits (1..64)
- DEPTH, 1, number of register stages (0..8); 0 = combinational bypass
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears all stages
- clken  input  1  shared clock enable; low = whole pipeline holds
- flush  input  1  synchronous; invalidates all in-flight data
- in_valid  input  1  din carries a valid sample this cycle
- din  input  WIDTH  input data
- out_valid  output  1  dout carries a valid sample
- dout  output  WIDTH  output data (last stage, or din when DEPTH=0)
- busy  output  1  at least one stage holds a valid sample
- level  output  max(1,$clog2(DEPTH+1))  count of valid samples in the pipeline

## Operation
- Stages s[0..DEPTH-1], each with data d[i] and valid v[i]; s[0] fed from din/in_valid; dout=d[DEPTH-1], out_valid=v[DEPTH-1].
- Priority per edge: reset > flush > clken.
- reset: all d[i]=0, v[i]=0, level=0. Output reset values: dout=0, out_valid=0, busy=0, level=0 (DEPTH≥1).
- flush (reset low): all v[i]=0, level=0; d[i] held; din/in_valid of that cycle discarded regardless of clken.
- clken high, no flush: d[i]<=d[i-1], v[i]<=v[i-1]; s[0] loads din/in_valid.
- clken low, no flush: all stages hold; level holds.
- level updated incrementally, not by popcount: level += (in_valid) − (out_valid), applied only on clken-high cycles; net zero when both set. Never exceeds DEPTH, never underflows.
- busy = (level != 0), combinational from level.
- DEPTH=0: dout=din, out_valid=in_valid, busy=0, level=0; clk/reset/clken/flush unused.

## Timing
- Latency: exactly DEPTH clken-high edges from din to dout; stalled cycles add delay but never drop or duplicate samples.
- Throughput: one sample per clken-high cycle; no backpressure output.
- Reset mid-operation: all in-flight samples lost; out_valid low from the next cycle.
- Flush and clken high together: flush wins; incoming sample dropped.
- Flush during stall: valid bits still cleared.
- Combinational paths: only DEPTH=0 (din→dout) and level→busy.

## Configuration
- DSP_PIPE_GATE_EN defined: a stage loads data only when its incoming valid is 1 (an invalid bubble leaves the old d[i] in place, saving toggle power), and dout is forced to 0 whenever out_valid=0.
- Not defined: data shifts every clken-high cycle regardless of valid; dout shows raw d[DEPTH-1] even when out_valid=0.
- Valid, level and busy behaviour identical in both builds.

## Structure
- Package dsp_pipe_pkg: DSP_WIDTH=48, DSP_PIPE_MAX_DEPTH=8, function for level width (max(1,clog2(DEPTH+1))).
- Sub-module dsp_pipe_cell: one stage (data+valid register with reset, flush, enable, gate option); top generates DEPTH instances and the level counter.
- Parameter check: DEPTH>DSP_PIPE_MAX_DEPTH or WIDTH outside 1..64 is an elaboration error.

## Test plan
- DEPTH=3, clken=1, in_valid=1, din=1,2,3,4 on consecutive cycles -> dout=1,2,3,4 three cycles later with out_valid=1; level ramps 1,2,3 then stays 3.
- DEPTH=3, load 0xA, 0xB, drop clken for 4 cycles then raise -> outputs and level frozen during stall; 0xA appears on the third clken-high edge after input, no duplication.
- DEPTH=4, 3 valid samples in flight, assert flush with clken=1 and in_valid=1 (din=0xFF) -> next cycle level=0, busy=0, out_valid=0 for 4 cycles; 0xFF never emerges.
- DEPTH=2, reset asserted together with flush and in_valid -> dout=0, out_valid=0, level=0 next cycle; then din=0x123456789ABC emerges after 2 cycles.
- DEPTH=2, alternating in_valid 1/0 with din=0x5,0x6,0x7 -> out_valid alternates; with DSP_PIPE_GATE_EN dout=0 on invalid cycles, without it dout=0x6 visible with out_valid=0.
- DEPTH=0, din=0xDEAD, in_valid=1 -> dout=0xDEAD, out_valid=1 same cycle; level=0, busy=0.
